// File: rtl/pistormx_txn_queue.sv
// Pi-side transaction queue: synchronizes Pi register writes into M68K_CLK, stages address/data, commits ops to a FIFO.
// Push lands 2 edges after the synchronized strobe; commits into a full queue are dropped (sticky Q_OVF); one op in flight at a time.
module pistormx_txn_queue #(
    parameter int DEPTH = 4
) (
    input  logic        M68K_CLK,
    input  logic        M68K_RST,
    input  logic        PI_WR,
    input  logic [1:0]  PI_A,
    input  logic [15:0] PI_D,
    output logic        OP_VALID,
    output logic [22:0] OP_A,
    output logic        OP_A0,
    output logic        OP_SZ,
    output logic        OP_RW,
    output logic [15:0] OP_DOUT,
    input  logic        OP_ACK,
    input  logic        OP_DONE,
    input  logic [15:0] OP_DIN,
    output logic [15:0] RD_DATA,
    output logic        PI_TXN_IN_PROGRESS,
    output logic        Q_FULL,
    output logic        Q_OVF
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [22:0] a;
        logic        a0;
        logic        sz;
        logic        rw;
        logic [15:0] dat;
    } op_ent_t;

    logic              w1_q, w1_d, w2_q, w2_d, w3_q, w3_d;
    logic [14:0]       stage_a_q, stage_a_d;
    logic              stage_a0_q, stage_a0_d;
    logic [15:0]       stage_d_q, stage_d_d;
    op_ent_t [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              inflight_q, inflight_d;
    logic              inflight_rw_q, inflight_rw_d;
    logic [15:0]       rd_data_q, rd_data_d;
    logic              ovf_q, ovf_d;

    logic    evt, op_valid, ack_take, push_ok, full;
    op_ent_t head, new_ent;

    assign head     = mem_q[rd_ptr_q];
    assign full     = (count_q == CW'(DEPTH));
    assign op_valid = (count_q != '0) & ~inflight_q;
    assign evt      = w2_q & ~w3_q;
    assign ack_take = OP_ACK & op_valid;
    assign new_ent  = '{a: {PI_D[7:0], stage_a_q}, a0: stage_a0_q,
                        sz: PI_D[8], rw: PI_D[9], dat: stage_d_q};

    always_comb begin
        w1_d          = PI_WR;
        w2_d          = w1_q;
        w3_d          = w2_q;
        stage_a_d     = stage_a_q;
        stage_a0_d    = stage_a0_q;
        stage_d_d     = stage_d_q;
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        inflight_d    = inflight_q;
        inflight_rw_d = inflight_rw_q;
        rd_data_d     = rd_data_q;
        ovf_d         = ovf_q;
        push_ok       = 1'b0;

        if (ack_take) begin
            rd_ptr_d      = rd_ptr_q + 1'b1;
            inflight_d    = 1'b1;
            inflight_rw_d = head.rw;
        end

        if (evt) begin
            case (PI_A)
                2'd0: stage_d_d = PI_D;
                2'd1: begin
                    stage_a_d  = PI_D[15:1];
                    stage_a0_d = PI_D[0];
                end
                2'd2: begin
                    // A simultaneous pop frees a slot, so a commit at full is still accepted.
                    if (!full || ack_take) begin
                        push_ok         = 1'b1;
                        mem_d[wr_ptr_q] = new_ent;
                        wr_ptr_d        = wr_ptr_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                default: begin
                    if (PI_D[3]) ovf_d = 1'b0;
                end
            endcase
        end

        count_d = count_q + CW'(push_ok) - CW'(ack_take);

        // Flush drops queued entries only; an op already handed to the engine still completes.
        if (evt && PI_A == 2'd3 && PI_D[2]) begin
            rd_ptr_d = wr_ptr_d;
            count_d  = '0;
        end

        if (OP_DONE && inflight_q) begin
            inflight_d = 1'b0;
            if (inflight_rw_q) rd_data_d = OP_DIN;
        end
    end

    always_ff @(posedge M68K_CLK or posedge M68K_RST) begin
        if (M68K_RST) begin
            w1_q          <= 1'b0;
            w2_q          <= 1'b0;
            w3_q          <= 1'b0;
            stage_a_q     <= '0;
            stage_a0_q    <= 1'b0;
            stage_d_q     <= '0;
            mem_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_rw_q <= 1'b0;
            rd_data_q     <= '0;
            ovf_q         <= 1'b0;
        end else begin
            w1_q          <= w1_d;
            w2_q          <= w2_d;
            w3_q          <= w3_d;
            stage_a_q     <= stage_a_d;
            stage_a0_q    <= stage_a0_d;
            stage_d_q     <= stage_d_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            inflight_rw_q <= inflight_rw_d;
            rd_data_q     <= rd_data_d;
            ovf_q         <= ovf_d;
        end
    end

    assign OP_VALID           = op_valid;
    assign OP_A               = head.a;
    assign OP_A0              = head.a0;
    assign OP_SZ              = head.sz;
    assign OP_RW              = head.rw;
    assign OP_DOUT            = head.dat;
    assign RD_DATA            = rd_data_q;
    assign PI_TXN_IN_PROGRESS = (count_q != '0) | inflight_q;
    assign Q_FULL             = full;
    assign Q_OVF              = ovf_q;
endmodule

// File: tb/tb_pistormx_txn_queue.sv
// Directed and randomized checks of pistormx_txn_queue against a queue-based reference model.
module tb_pistormx_txn_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pi_wr;
    logic [1:0]  pi_a;
    logic [15:0] pi_d;
    logic        op_valid;
    logic [22:0] op_a;
    logic        op_a0, op_sz, op_rw;
    logic [15:0] op_dout;
    logic        op_ack, op_done;
    logic [15:0] op_din;
    logic [15:0] rd_data;
    logic        txn, q_full, q_ovf;

    pistormx_txn_queue #(.DEPTH(DEPTH)) dut (
        .M68K_CLK(clk), .M68K_RST(rst), .PI_WR(pi_wr), .PI_A(pi_a), .PI_D(pi_d),
        .OP_VALID(op_valid), .OP_A(op_a), .OP_A0(op_a0), .OP_SZ(op_sz), .OP_RW(op_rw),
        .OP_DOUT(op_dout), .OP_ACK(op_ack), .OP_DONE(op_done), .OP_DIN(op_din),
        .RD_DATA(rd_data), .PI_TXN_IN_PROGRESS(txn), .Q_FULL(q_full), .Q_OVF(q_ovf)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: committed ops as a plain queue, plus the one op the engine holds.
    typedef struct {
        logic [22:0] a;
        logic        a0;
        logic        sz;
        logic        rw;
        logic [15:0] d;
    } ent_t;

    ent_t        mq[$];
    bit          m_inflight, m_irw, m_ovf, m_a0;
    logic [15:0] m_rd, m_sd;
    logic [14:0] m_sa;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_valid();
        return (mq.size() != 0) && !m_inflight;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_inflight = 0; m_irw = 0; m_ovf = 0; m_a0 = 0;
        m_rd = '0; m_sd = '0; m_sa = '0;
    endtask

    task automatic model_event(input logic [1:0] a, input logic [15:0] d);
        ent_t e;
        case (a)
            2'd0: m_sd = d;
            2'd1: begin m_sa = d[15:1]; m_a0 = d[0]; end
            2'd2: begin
                e.a = {d[7:0], m_sa}; e.a0 = m_a0; e.sz = d[8]; e.rw = d[9]; e.d = m_sd;
                if (mq.size() == DEPTH) m_ovf = 1;
                else mq.push_back(e);
            end
            default: begin
                if (d[2]) mq.delete();
                if (d[3]) m_ovf = 0;
            end
        endcase
    endtask

    task automatic model_ack();
        if (m_valid()) begin
            m_irw = mq[0].rw;
            mq.delete(0);
            m_inflight = 1;
        end
    endtask

    task automatic model_done(input logic [15:0] din);
        if (m_inflight) begin
            m_inflight = 0;
            if (m_irw) m_rd = din;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(op_valid), 32'(m_valid()));
        chk({tag, ".txn"},   32'(txn), 32'((mq.size() != 0) || m_inflight));
        chk({tag, ".full"},  32'(q_full), 32'(mq.size() == DEPTH));
        chk({tag, ".ovf"},   32'(q_ovf), 32'(m_ovf));
        chk({tag, ".rd"},    32'(rd_data), 32'(m_rd));
        if (mq.size() != 0) begin
            chk({tag, ".a"},    32'(op_a), 32'(mq[0].a));
            chk({tag, ".a0"},   32'(op_a0), 32'(mq[0].a0));
            chk({tag, ".sz"},   32'(op_sz), 32'(mq[0].sz));
            chk({tag, ".rw"},   32'(op_rw), 32'(mq[0].rw));
            chk({tag, ".dout"}, 32'(op_dout), 32'(mq[0].d));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".valid"}, 32'(op_valid), 32'd0);
        chk({tag, ".a"},     32'(op_a), 32'd0);
        chk({tag, ".lanes"}, 32'({op_a0, op_sz, op_rw}), 32'd0);
        chk({tag, ".dout"},  32'(op_dout), 32'd0);
        chk({tag, ".rd"},    32'(rd_data), 32'd0);
        chk({tag, ".flags"}, 32'({txn, q_full, q_ovf}), 32'd0);
    endtask

    // Strobe high 3 clocks, low 2; optional ACK pulse lands on the push edge.
    task automatic pi_write(input logic [1:0] a, input logic [15:0] d, input bit ack_at_push);
        @(negedge clk);
        pi_a = a; pi_d = d; pi_wr = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        chk("pre_push.valid", 32'(op_valid), 32'(m_valid()));
        chk("pre_push.txn", 32'(txn), 32'((mq.size() != 0) || m_inflight));
        if (ack_at_push) begin
            @(negedge clk);
            op_ack = 1'b1;
        end
        @(posedge clk); #1;
        op_ack = 1'b0;
        if (ack_at_push) model_ack();
        model_event(a, d);
        check_all("write");
        @(negedge clk);
        pi_wr = 1'b0;
        @(posedge clk);
        @(posedge clk);
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        op_ack = 1'b1;
        @(posedge clk); #1;
        op_ack = 1'b0;
        model_ack();
        check_all("ack");
    endtask

    task automatic done_pulse(input logic [15:0] din);
        @(negedge clk);
        op_done = 1'b1; op_din = din;
        @(posedge clk); #1;
        op_done = 1'b0;
        model_done(din);
        check_all("done");
    endtask

    initial begin
        rst = 1'b1; pi_wr = 1'b0; pi_a = '0; pi_d = '0;
        op_ack = 1'b0; op_done = 1'b0; op_din = '0;
        model_reset();
        #1;
        check_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Word write: byte address 0x121235 -> A[23:1] = 0x09091A, odd byte lane set
        pi_write(2'd1, 16'h1235, 0);
        pi_write(2'd0, 16'hBEEF, 0);
        pi_write(2'd2, 16'h0012, 0);
        chk("t1.op_a", 32'(op_a), 32'h0009091A);
        chk("t1.op_a0", 32'(op_a0), 32'd1);
        chk("t1.dout", 32'(op_dout), 32'h0000BEEF);
        chk("t1.szrw", 32'({op_sz, op_rw}), 32'd0);
        ack_pulse();
        done_pulse(16'h0000);
        chk("t1.txn_idle", 32'(txn), 32'd0);

        // Read returns data; a later write cycle leaves it untouched
        pi_write(2'd2, 16'h0200, 0);
        ack_pulse();
        done_pulse(16'h55AA);
        chk("t2.rd", 32'(rd_data), 32'h000055AA);
        pi_write(2'd2, 16'h0000, 0);
        ack_pulse();
        done_pulse(16'h1111);
        chk("t2.rd_kept", 32'(rd_data), 32'h000055AA);

        // Overflow with stalled engine
        for (int i = 0; i < 5; i++) begin
            pi_write(2'd0, 16'hA000 + 16'(i), 0);
            pi_write(2'd2, 16'h0030 + 16'(i), 0);
            if (i == 3) chk("t3.full4", 32'({q_full, q_ovf}), 32'b10);
        end
        chk("t3.ovf", 32'({q_full, q_ovf}), 32'b11);
        pi_write(2'd3, 16'h0008, 0);
        chk("t3.ovf_clr", 32'(q_ovf), 32'd0);

        // Commit at full coinciding with ACK, then drain in order across the wrap
        pi_write(2'd2, 16'h0077, 1);
        chk("t4.no_ovf", 32'({q_full, q_ovf}), 32'b10);
        done_pulse(16'h0000);
        for (int i = 0; i < 4; i++) begin
            ack_pulse();
            done_pulse(16'h0000);
        end
        chk("t4.empty", 32'(txn), 32'd0);

        // Flush while one op is in flight
        for (int i = 0; i < 4; i++) pi_write(2'd2, 16'h0040 + 16'(i), 0);
        ack_pulse();
        pi_write(2'd3, 16'h0004, 0);
        chk("t5.valid", 32'(op_valid), 32'd0);
        chk("t5.txn", 32'(txn), 32'd1);
        done_pulse(16'h0000);
        chk("t5.txn_off", 32'(txn), 32'd0);

        // Asynchronous reset with two queued and one in flight
        for (int i = 0; i < 3; i++) pi_write(2'd2, 16'h0250 + 16'(i), 0);
        ack_pulse();
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_zero("t6.async");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        done_pulse(16'hABCD);
        chk("t6.rd_zero", 32'(rd_data), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1:    pi_write(2'd0, 16'($urandom), 0);
                2, 3:    pi_write(2'd1, 16'($urandom), 0);
                4, 5:    pi_write(2'd2, 16'($urandom), ($urandom_range(0, 3) == 0));
                6:       pi_write(2'd3, 16'($urandom), 0);
                7:       ack_pulse();
                default: done_pulse(16'($urandom));
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
